wide_mag_compare: RTL
=====================

# wide_mag_compare

Parametrised, multi-cycle magnitude comparator: the wide-operand successor to the 4-bit cascadable comparator. It compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and stops early at the first differing chunk. Cascade inputs follow the 4-bit part's truth table when all chunks are equal, and an optional two's-complement mode is available. It sits behind a start/done handshake for use by sequential datapath controllers.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; N = WIDTH/CHUNK chunks.
- SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- iagb  input  1  cascade A>B; captured with operands.
- ialb  input  1  cascade A<B; captured with operands.
- iaeb  input  1  cascade A=B; captured with operands.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- fagb  output  1  result A>B.
- falb  output  1  result A<B.
- faeb  output  1  result A=B.

## Operation
- States: IDLE, CMP.
- IDLE:
  - start=1 at an edge: capture a, b and the cascade inputs; set chunk index to N-1; busy=1; go to CMP.
- CMP, at each edge, compare captured chunk[idx] of A and B as unsigned CHUNK-bit values.
  - When SIGNED=1, invert the MSB of both operands in chunk N-1 before comparing.
  - Chunks differ: write fagb/falb/faeb = (1,0,0) if A>B, else (0,1,0); pulse done; busy=0; go to IDLE.
  - Chunks equal and idx>0: decrement idx.
  - Chunks equal and idx=0: resolve from the captured cascade inputs, then pulse done, busy=0, go to IDLE:
    - iaeb=1 -> (0,0,1), regardless of iagb/ialb.
    - iagb=1, ialb=0, iaeb=0 -> (1,0,0).
    - iagb=0, ialb=1, iaeb=0 -> (0,1,0).
    - iagb=1, ialb=1, iaeb=0 -> (0,0,0).
    - all three 0 -> (1,1,0).
- start while busy=1: ignored; captured operands are not disturbed.
- Result outputs hold their last written value until the next done. They do not change when a new comparison starts.
- Live a/b/cascade changes after the accepting edge have no effect.

## Timing
- Reset values: busy=0, done=0, fagb=0, falb=0, faeb=0; state IDLE. The reset is asynchronous.
- Accepting edge = E0. busy rises after E0.
- A difference first found in the chunk processed at edge E0+k (k=1..N) gives done=1, with results, after edge E0+k.
- Minimum latency is 1 cycle (MSB chunk differs). Maximum is N cycles (equal, or difference in the LSB chunk).
- done and the busy fall are registered at the same edge.
- start=1 in the cycle where done=1 is accepted at the next edge. This gives back-to-back throughput with no idle cycle.
- rst asserted mid-CMP: immediately returns to IDLE with all outputs 0. No done is generated for the aborted operation.
- N=1 (WIDTH=CHUNK) is legal: every comparison takes exactly 1 cycle.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless stated.
- Early exit: a=0x3A00, b=0x1A00, cascade (0,0,1) -> done one cycle after E0; fagb=1, falb=0, faeb=0.
- Full latency: a=0x1234, b=0x1235 -> done 4 cycles after E0; (0,1,0). Also a=0x1235, b=0x1234 -> (1,0,0) after 4 cycles.
- Cascade truth table, a=b=0x0033, all after 4 cycles:
  - iaeb=1 -> (0,0,1).
  - iagb=1 only -> (1,0,0).
  - ialb=1 only -> (0,1,0).
  - iagb=ialb=1 -> (0,0,0).
  - all 0 -> (1,1,0).
- Signed mode: a=0xFFFF, b=0x0001.
  - SIGNED=0 -> (1,0,0) after 1 cycle.
  - SIGNED=1 -> (0,1,0) after 1 cycle.
  - SIGNED=1 with a=0x8000, b=0x7FFF -> (0,1,0).
- Handshake:
  - start pulsed while busy with new operands -> ignored; the first result is unchanged.
  - start held high through done -> second operation accepted the edge after done; results hold the old values until the second done.
- Reset mid-operation: assert rst 2 cycles after E0 for a=0x1234, b=0x1235 -> all outputs 0 immediately, no done pulse. A fresh start after release completes normally.

Source files
------------

// File: rtl/wide_mag_compare.sv
// Purpose: multi-cycle WIDTH-bit magnitude comparator, MSB chunk first, early exit on first difference.
// Latency: 1..N cycles after the accepting edge (N = WIDTH/CHUNK); done is a one-cycle pulse.
// Backpressure: start is only sampled while busy=0; requests during a comparison are dropped.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             request; accepted on an edge where busy=0
//   a, b              WIDTH-bit operands, captured on the accepting edge
//   iagb, ialb, iaeb  cascade inputs, captured with the operands, used only when A==B
//   busy              high while a comparison is in progress
//   done              one-cycle pulse when results are written
//   fagb, falb, faeb  result flags; hold their value until the next done
module wide_mag_compare #(
  parameter int WIDTH  = 16,
  parameter int CHUNK  = 4,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             iagb,
  input  logic             ialb,
  input  logic             iaeb,
  output logic             busy,
  output logic             done,
  output logic             fagb,
  output logic             falb,
  output logic             faeb
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the chunk comparator itself never needs to know about sign.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       casc;      // {iagb, ialb, iaeb} captured at accept
  logic [IW-1:0]    cnt;       // chunks remaining after the current one

  logic [CHUNK-1:0] a_top;
  logic [CHUNK-1:0] b_top;
  logic             chunk_ne;
  logic             chunk_gt;
  logic             last_chunk;

  // Operands are shifted left each cycle, so the chunk under test is always
  // the top CHUNK bits; this avoids a variable-index mux across the word.
  always_comb begin
    a_top      = a_sh[WIDTH-1 -: CHUNK];
    b_top      = b_sh[WIDTH-1 -: CHUNK];
    chunk_ne   = (a_top != b_top);
    chunk_gt   = (a_top > b_top);
    last_chunk = (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      fagb  <= 1'b0;
      falb  <= 1'b0;
      faeb  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      casc  <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a ^ SIGN_MASK;
            b_sh  <= b ^ SIGN_MASK;
            casc  <= {iagb, ialb, iaeb};
            cnt   <= IW'(N - 1);
            busy  <= 1'b1;
            state <= CMP;
          end
        end
        CMP: begin
          if (chunk_ne) begin
            fagb  <= chunk_gt;
            falb  <= ~chunk_gt;
            faeb  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!last_chunk) begin
            cnt  <= cnt - 1'b1;
            a_sh <= a_sh << CHUNK;
            b_sh <= b_sh << CHUNK;
          end else begin
            // Operands equal: cascade table of the 4-bit part. iaeb dominates;
            // otherwise each flag is set unless the opposite cascade input is set,
            // which yields (0,0,0) for both set and (1,1,0) for neither.
            fagb  <= ~casc[0] & ~casc[1];
            falb  <= ~casc[0] & ~casc[2];
            faeb  <= casc[0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
